// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the servo PWM capture block and the joint PWM generators:
// FSM state encodings and the standard servo timing constants at 50 MHz.
package pwm_capture_pkg;

    // Capture FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // Servo timing in 50 MHz clock cycles
    localparam int SERVO_PERIOD_CYC = 1_000_000;  // 20 ms frame
    localparam int SERVO_MIN_CYC    = 25_000;     // 0.5 ms
    localparam int SERVO_MID_CYC    = 75_000;     // 1.5 ms
    localparam int SERVO_MAX_CYC    = 125_000;    // 2.5 ms
    localparam int SIGNAL_LOST_CYC  = 2_000_000;  // 40 ms without an edge

endpackage

// File: rtl/pwm_capture_sync_edge.sv
// Two-flop synchronizer plus a history flop, giving single-cycle rise/fall
// pulses on the synchronized level. Reset value is a parameter so the same
// block serves active-low KEY inputs and idle-high PWM lines.
module sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    // Synchronize the asynchronous input and keep one cycle of history
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// Servo-pulse receiver: measures high time and rise-to-rise period of the PWM
// input in clock cycles, flags out-of-range high times and loss of signal.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 21,
    parameter int TIMEOUT_CYC = SIGNAL_LOST_CYC,
    parameter int MIN_HIGH    = SERVO_MIN_CYC,
    parameter int MAX_HIGH    = SERVO_MAX_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cyc,
    output logic [CNT_W-1:0] period_cyc,
    output logic             valid,
    output logic             range_err,
    output logic             lost
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] HI_MIN  = CNT_W'(MIN_HIGH);
    localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(MAX_HIGH);

    logic             rise, fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_tmp;
    logic [1:0]       state;
    logic             timeout;

    // Idle-high reset: a line held high through reset produces no rise
    sync_edge #(.RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pwm_in),
        .rise (rise),
        .fall (fall)
    );

    assign timeout = (cnt == CNT_TO);

    // Cycle counter restarted on every rise, saturating instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_ONE;
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Measurement FSM and registered report; an edge beats a same-cycle timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hi_tmp     <= '0;
            high_cyc   <= '0;
            period_cyc <= '0;
            valid      <= 1'b0;
            range_err  <= 1'b0;
            lost       <= 1'b1;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // First rise only starts a period; nothing to report yet
                    if (rise) state <= ST_HIGH;
                end
                ST_HIGH: begin
                    if (fall) begin
                        hi_tmp <= cnt;
                        state  <= ST_LOW;
                    end else if (timeout && !rise) begin
                        lost  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        high_cyc   <= hi_tmp;
                        period_cyc <= cnt;
                        valid      <= 1'b1;
                        lost       <= 1'b0;
                        range_err  <= (hi_tmp < HI_MIN) | (hi_tmp > HI_MAX);
                        state      <= ST_HIGH;
                    end else if (timeout && !fall) begin
                        lost  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture with scaled-down timing parameters.
// A per-cycle monitor compares every output against an event-level reference
// model; a vector table and directed sequences check absolute report values.
module tb_pwm_capture;

    localparam int CW   = 12;
    localparam int TO   = 2000;
    localparam int MINH = 25;
    localparam int MAXH = 125;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pwm_in = 1'b1;
    logic [CW-1:0] high_cyc, period_cyc;
    logic          valid, range_err, lost;

    pwm_capture #(
        .CNT_W       (CW),
        .TIMEOUT_CYC (TO),
        .MIN_HIGH    (MINH),
        .MAX_HIGH    (MAXH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .high_cyc   (high_cyc),
        .period_cyc (period_cyc),
        .valid      (valid),
        .range_err  (range_err),
        .lost       (lost)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    logic rst_q  = 1'b1;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (event level) ----------------
    // Edges are recorded by the cycle index of the first clock edge that
    // samples the new level. A rise at s is reported at cycle s+2; a train
    // is lost TO+2 cycles after its last rise unless another rise comes
    // within TO cycles.
    typedef struct {
        int   t;
        int   hi;
        int   per;
        logic err;
    } rep_t;

    rep_t exp_q[$];
    int   lost_q[$];
    bit   have_rise = 0, have_fall = 0;
    int   r_s = 0, f_s = 0;
    int   hi_e = 0, per_e = 0;
    logic err_e = 1'b0, lost_e = 1'b1, valid_e = 1'b0;

    function automatic void model_edge(input logic lvl, input int s);
        rep_t r;
        if (lvl) begin
            if (have_rise && (s - r_s) <= TO) begin
                if (lost_q.size() > 0) void'(lost_q.pop_back());
                if (have_fall) begin
                    r.t   = s + 2;
                    r.hi  = f_s - r_s;
                    r.per = s - r_s;
                    r.err = (r.hi < MINH) || (r.hi > MAXH);
                    exp_q.push_back(r);
                end
            end
            have_rise = 1;
            have_fall = 0;
            r_s = s;
            lost_q.push_back(s + TO + 2);
        end else if (have_rise) begin
            have_fall = 1;
            f_s = s;
        end
    endfunction

    // DUT reports captured for the table and directed checks
    rep_t dut_q[$];

    // Per-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        rep_t r, d;
        valid_e = 1'b0;
        if (rst_q) begin
            exp_q.delete();
            lost_q.delete();
            have_rise = 0;
            have_fall = 0;
            hi_e = 0; per_e = 0; err_e = 1'b0; lost_e = 1'b1;
        end else begin
            if (lost_q.size() > 0 && lost_q[0] == cyc) begin
                void'(lost_q.pop_front());
                lost_e = 1'b1;
            end
            if (exp_q.size() > 0 && exp_q[0].t == cyc) begin
                r = exp_q.pop_front();
                valid_e = 1'b1;
                hi_e = r.hi; per_e = r.per; err_e = r.err; lost_e = 1'b0;
            end
        end
        chk("valid", int'(valid), int'(valid_e));
        chk("lost", int'(lost), int'(lost_e));
        chk("high_cyc", int'(high_cyc), hi_e);
        chk("period_cyc", int'(period_cyc), per_e);
        chk("range_err", int'(range_err), int'(err_e));
        if (valid === 1'b1) begin
            d.t = cyc; d.hi = int'(high_cyc); d.per = int'(period_cyc); d.err = range_err;
            dut_q.push_back(d);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic lvl, input int n);
        if (lvl != pwm_in) model_edge(lvl, cyc + 1);
        pwm_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Line level changes during reset are invisible to the DUT
    task automatic do_reset(input logic lvl);
        rst = 1'b1;
        pwm_in = lvl;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int   h;
        int   p;
        int   exp_hi;
        int   exp_per;
        logic exp_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int h, p;
        tbl[0] = '{75,  1000, 75,  1000, 1'b0};
        tbl[1] = '{75,  1000, 75,  1000, 1'b0};
        tbl[2] = '{20,  1000, 20,  1000, 1'b1};
        tbl[3] = '{130, 1000, 130, 1000, 1'b1};
        tbl[4] = '{25,  300,  25,  300,  1'b0};
        tbl[5] = '{125, 300,  125, 300,  1'b0};
        tbl[6] = '{24,  300,  24,  300,  1'b1};
        tbl[7] = '{126, 300,  126, 300,  1'b1};
        tbl[8] = '{1,   3,    1,   3,    1'b1};
        tbl[9] = '{1,   3,    1,   3,    1'b1};

        @(posedge clk);
        #1;
        do_reset(1'b1);
        chk("reset lost", int'(lost), 1);
        chk("reset high_cyc", int'(high_cyc), 0);
        chk("reset period_cyc", int'(period_cyc), 0);

        // Table: each entry is reported at the rise of the next one
        drive(1'b0, 20);
        dut_q.delete();
        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].h);
            drive(1'b0, tbl[i].p - tbl[i].h);
        end
        drive(1'b1, 10);
        chk("table report count", dut_q.size(), 10);
        for (int i = 0; i < 10 && i < dut_q.size(); i++) begin
            chk($sformatf("tbl[%0d] high", i), dut_q[i].hi, tbl[i].exp_hi);
            chk($sformatf("tbl[%0d] period", i), dut_q[i].per, tbl[i].exp_per);
            chk($sformatf("tbl[%0d] range_err", i), int'(dut_q[i].err), int'(tbl[i].exp_err));
        end

        // Stuck high after the train: lost, values held, no valid
        dut_q.delete();
        drive(1'b1, 2100);
        chk("stuck-high lost", int'(lost), 1);
        chk("stuck-high held high", int'(high_cyc), 1);
        chk("stuck-high held period", int'(period_cyc), 3);
        chk("stuck-high no valid", dut_q.size(), 0);

        // Stuck low after a fresh nominal train
        drive(1'b0, 100);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 75);
            drive(1'b0, 925);
        end
        drive(1'b0, 2100);
        chk("stuck-low reports", dut_q.size(), 2);
        chk("stuck-low lost", int'(lost), 1);
        chk("stuck-low held high", int'(high_cyc), 75);
        chk("stuck-low held period", int'(period_cyc), 1000);

        // Line high through reset: fall at 500, rise at 1000, no report there
        do_reset(1'b1);
        dut_q.delete();
        drive(1'b1, 500);
        drive(1'b0, 500);
        drive(1'b1, 75);
        drive(1'b0, 925);
        drive(1'b1, 10);
        chk("post-reset report count", dut_q.size(), 1);
        if (dut_q.size() > 0) begin
            chk("post-reset high", dut_q[0].hi, 75);
            chk("post-reset period", dut_q[0].per, 1000);
        end

        // Reset in the middle of a HIGH phase discards the partial pulse
        drive(1'b0, 90);
        drive(1'b1, 40);
        do_reset(1'b1);
        chk("mid-reset lost", int'(lost), 1);
        chk("mid-reset high_cyc", int'(high_cyc), 0);
        dut_q.delete();
        drive(1'b1, 30);
        drive(1'b0, 50);
        drive(1'b1, 60);
        drive(1'b0, 240);
        drive(1'b1, 10);
        chk("mid-reset report count", dut_q.size(), 1);
        if (dut_q.size() > 0) begin
            chk("mid-reset high", dut_q[0].hi, 60);
            chk("mid-reset period", dut_q[0].per, 300);
            chk("mid-reset range_err", int'(dut_q[0].err), 0);
        end

        // Random pulse train, checked cycle by cycle by the model
        drive(1'b0, 17);
        for (int k = 0; k < 40; k++) begin
            h = $urandom_range(200, 1);
            p = h + $urandom_range(300, 1);
            drive(1'b1, h);
            drive(1'b0, p - h);
        end
        drive(1'b1, 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
